// File: rtl/csr_if.sv
// CSR access bus between the pipeline (master) and the CSR unit (slave).
//   read_enable_csr / csr_read_index        : read strobe and address
//   write_enable_csr / csr_op / csr_write_* : write strobe, operation, address, operand
//   csr_read_data / csr_illegal             : combinational response from the unit
interface csr_if;
    logic        read_enable_csr;
    logic        write_enable_csr;
    logic [1:0]  csr_op;
    logic [11:0] csr_read_index;
    logic [11:0] csr_write_index;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;
    logic        csr_illegal;

    modport master (
        output read_enable_csr, write_enable_csr, csr_op,
               csr_read_index, csr_write_index, csr_write_data,
        input  csr_read_data, csr_illegal
    );

    modport slave (
        input  read_enable_csr, write_enable_csr, csr_op,
               csr_read_index, csr_write_index, csr_write_data,
        output csr_read_data, csr_illegal
    );
endinterface

// File: rtl/control_status_register_unit.sv
// CSR unit for the phoeniX core: approximation-control CSRs, mcycle/minstret
// counters and mcountinhibit, with write/set/clear operations and illegal-access flag.
// All state updates on the falling clock edge; reads are combinational.
// Ports:
//   clk           core clock (state changes on negedge)
//   reset         asynchronous active-low reset
//   bus           csr_if.slave access bus (read/write strobes, indices, data, illegal)
//   instret_pulse one instruction retired this cycle
//   approx_ctrl   approximation CSR i at bits [32i+31:32i]
// Optional feature: define USER_COUNTER_SHADOW_EN to implement the read-only user
// shadows cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82).
module control_status_register_unit #(
    parameter int unsigned NUM_APPROX_CSR  = 3,
    parameter logic [11:0] APPROX_CSR_BASE = 12'h800,
    parameter int unsigned COUNTER_WIDTH   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    csr_if.slave                           bus,
    input  logic                           instret_pulse,
    output logic [32*NUM_APPROX_CSR-1:0]   approx_ctrl
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HI_W = COUNTER_WIDTH - XLEN;

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_INHIBIT   = 12'h320;
`ifdef USER_COUNTER_SHADOW_EN
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

    localparam logic [11:0] NUM_APPROX_12 = 12'(NUM_APPROX_CSR);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_APPROX,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH,
        SEL_INHIBIT,
        SEL_CYCLE,
        SEL_CYCLEH,
        SEL_INSTRET,
        SEL_INSTRETH
    } csr_sel_e;

    // Architectural state
    logic [XLEN-1:0]          approx_q [NUM_APPROX_CSR];
    logic [COUNTER_WIDTH-1:0] mcycle_q;
    logic [COUNTER_WIDTH-1:0] minstret_q;
    logic                     cy_q;
    logic                     ir_q;

    // Next-state
    logic [XLEN-1:0]          approx_d [NUM_APPROX_CSR];
    logic [COUNTER_WIDTH-1:0] mcycle_d;
    logic [COUNTER_WIDTH-1:0] minstret_d;
    logic                     cy_d;
    logic                     ir_d;

    // Access decode
    csr_sel_e                 rd_sel;
    csr_sel_e                 wr_sel;
    logic [11:0]              rd_off;
    logic [11:0]              wr_off;
    logic                     rd_bad;
    logic                     wr_bad;
    logic                     wr_ro;
    logic                     wr_fire;
    logic [XLEN-1:0]          wr_old;
    logic [XLEN-1:0]          wr_new;

    // Map a CSR index to the register it selects; approximation window wins on overlap.
    function automatic csr_sel_e decode(input logic [11:0] idx);
        csr_sel_e    s;
        logic [11:0] off;
        off = idx - APPROX_CSR_BASE;
        case (idx)
            ADDR_MCYCLE:    s = SEL_MCYCLE;
            ADDR_MCYCLEH:   s = SEL_MCYCLEH;
            ADDR_MINSTRET:  s = SEL_MINSTRET;
            ADDR_MINSTRETH: s = SEL_MINSTRETH;
            ADDR_INHIBIT:   s = SEL_INHIBIT;
`ifdef USER_COUNTER_SHADOW_EN
            ADDR_CYCLE:     s = SEL_CYCLE;
            ADDR_CYCLEH:    s = SEL_CYCLEH;
            ADDR_INSTRET:   s = SEL_INSTRET;
            ADDR_INSTRETH:  s = SEL_INSTRETH;
`endif
            default:        s = SEL_NONE;
        endcase
        if (off < NUM_APPROX_12) begin
            s = SEL_APPROX;
        end
        return s;
    endfunction

    // Current 32-bit view of the selected register; high halves zero-extended.
    function automatic logic [XLEN-1:0] value_of(input csr_sel_e sel, input logic [11:0] off);
        logic [XLEN-1:0] v;
        v = '0;
        case (sel)
            SEL_APPROX: begin
                for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
                    if (off == 12'(i)) begin
                        v = approx_q[i];
                    end
                end
            end
            SEL_MCYCLE,   SEL_CYCLE:    v = mcycle_q[XLEN-1:0];
            SEL_MCYCLEH,  SEL_CYCLEH:   v = XLEN'(mcycle_q[COUNTER_WIDTH-1:XLEN]);
            SEL_MINSTRET, SEL_INSTRET:  v = minstret_q[XLEN-1:0];
            SEL_MINSTRETH, SEL_INSTRETH: v = XLEN'(minstret_q[COUNTER_WIDTH-1:XLEN]);
            SEL_INHIBIT:                v = {{(XLEN-3){1'b0}}, ir_q, 1'b0, cy_q};
            default:                    v = '0;
        endcase
        return v;
    endfunction

    // Combinational read data, gated by the read strobe and a valid index.
    always_comb begin
        rd_off            = bus.csr_read_index - APPROX_CSR_BASE;
        rd_sel            = decode(bus.csr_read_index);
        rd_bad            = (rd_sel == SEL_NONE);
        bus.csr_read_data = '0;
        if (bus.read_enable_csr && !rd_bad) begin
            bus.csr_read_data = value_of(rd_sel, rd_off);
        end
    end

    // Write port decode and read-modify-write operand.
    always_comb begin
        wr_off  = bus.csr_write_index - APPROX_CSR_BASE;
        wr_sel  = decode(bus.csr_write_index);
        wr_ro   = (wr_sel == SEL_CYCLE)   || (wr_sel == SEL_CYCLEH) ||
                  (wr_sel == SEL_INSTRET) || (wr_sel == SEL_INSTRETH);
        wr_bad  = (wr_sel == SEL_NONE) || wr_ro || (bus.csr_op == OP_RSVD);
        wr_fire = bus.write_enable_csr && !wr_bad;
        wr_old  = value_of(wr_sel, wr_off);
        case (bus.csr_op)
            OP_WRITE: wr_new = bus.csr_write_data;
            OP_SET:   wr_new = wr_old | bus.csr_write_data;
            OP_CLEAR: wr_new = wr_old & ~bus.csr_write_data;
            default:  wr_new = wr_old;
        endcase
    end

    assign bus.csr_illegal = (bus.read_enable_csr && rd_bad) ||
                             (bus.write_enable_csr && wr_bad);

    // Next-state: counter increments use the inhibit bits held before this edge;
    // a write to either half of a counter replaces that counter's increment.
    always_comb begin
        for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
            approx_d[i] = approx_q[i];
        end
        mcycle_d   = cy_q ? mcycle_q : mcycle_q + CNT_ONE;
        minstret_d = (instret_pulse && !ir_q) ? minstret_q + CNT_ONE : minstret_q;
        cy_d       = cy_q;
        ir_d       = ir_q;

        if (wr_fire) begin
            case (wr_sel)
                SEL_APPROX: begin
                    for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
                        if (wr_off == 12'(i)) begin
                            approx_d[i] = wr_new;
                        end
                    end
                end
                SEL_MCYCLE:    mcycle_d   = {mcycle_q[COUNTER_WIDTH-1:XLEN], wr_new};
                SEL_MCYCLEH:   mcycle_d   = {wr_new[HI_W-1:0], mcycle_q[XLEN-1:0]};
                SEL_MINSTRET:  minstret_d = {minstret_q[COUNTER_WIDTH-1:XLEN], wr_new};
                SEL_MINSTRETH: minstret_d = {wr_new[HI_W-1:0], minstret_q[XLEN-1:0]};
                SEL_INHIBIT: begin
                    cy_d = wr_new[0];
                    ir_d = wr_new[2];
                end
                default: ;
            endcase
        end
    end

    // State register, falling edge; reset clears immediately and drops any pending write.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
                approx_q[i] <= '0;
            end
            mcycle_q   <= '0;
            minstret_q <= '0;
            cy_q       <= 1'b0;
            ir_q       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
                approx_q[i] <= approx_d[i];
            end
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            cy_q       <= cy_d;
            ir_q       <= ir_d;
        end
    end

    // Flatten approximation CSRs for the execution units.
    always_comb begin
        approx_ctrl = '0;
        for (int unsigned i = 0; i < NUM_APPROX_CSR; i++) begin
            approx_ctrl[XLEN*i +: XLEN] = approx_q[i];
        end
    end

endmodule

// File: tb/tb_control_status_register_unit.sv
// Directed bench for control_status_register_unit with a queue scoreboard.
// Stimulus changes inputs just after each falling edge and pushes the expected
// read data / illegal flag / approx_ctrl; the monitor compares on the rising edge.
module tb_control_status_register_unit;

    typedef struct packed {
        logic [31:0] d;
        logic        i;
        logic [95:0] a;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        instret_pulse;
    logic [95:0] approx_ctrl;

    csr_if bus ();

    control_status_register_unit dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .instret_pulse (instret_pulse),
        .approx_ctrl   (approx_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks   = 0;
    int    failures = 0;
    logic  chk_en   = 1'b0;
    logic  rst_v    = 1'b0;
    logic  pulse_v  = 1'b0;
    logic [95:0] approx_exp = '0;

    exp_t  cur_e;
    string cur_t;

    // Monitor: compare DUT response with the oldest expectation.
    always @(posedge clk) begin
        if (chk_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: response with no expectation queued");
            end else begin
                cur_e = exp_q.pop_front();
                cur_t = tag_q.pop_front();
                if (bus.csr_read_data !== cur_e.d || bus.csr_illegal !== cur_e.i ||
                    approx_ctrl !== cur_e.a) begin
                    failures++;
                    $display("FAIL %s: got data=%h illegal=%b approx=%h, expected data=%h illegal=%b approx=%h",
                             cur_t, bus.csr_read_data, bus.csr_illegal, approx_ctrl,
                             cur_e.d, cur_e.i, cur_e.a);
                end
            end
        end
    end

    task automatic slot(input logic re, input logic [11:0] ridx,
                        input logic we, input logic [1:0] op, input logic [11:0] widx,
                        input logic [31:0] wdata, input logic chk,
                        input logic [31:0] ed, input logic ei, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        reset                = rst_v;
        instret_pulse        = pulse_v;
        bus.read_enable_csr  = re;
        bus.csr_read_index   = ridx;
        bus.write_enable_csr = we;
        bus.csr_op           = op;
        bus.csr_write_index  = widx;
        bus.csr_write_data   = wdata;
        chk_en               = chk;
        if (chk) begin
            e.d = ed;
            e.i = ei;
            e.a = approx_exp;
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic rd(input logic [11:0] ridx, input logic [31:0] ed, input logic ei,
                      input string tag);
        slot(1'b1, ridx, 1'b0, 2'b00, 12'h000, 32'h0, 1'b1, ed, ei, tag);
    endtask

    task automatic wr(input logic [11:0] widx, input logic [1:0] op, input logic [31:0] wdata);
        slot(1'b0, 12'h000, 1'b1, op, widx, wdata, 1'b0, 32'h0, 1'b0, "");
    endtask

    initial begin
        reset                = 1'b0;
        instret_pulse        = 1'b0;
        bus.read_enable_csr  = 1'b0;
        bus.write_enable_csr = 1'b0;
        bus.csr_op           = 2'b00;
        bus.csr_read_index   = 12'h000;
        bus.csr_write_index  = 12'h000;
        bus.csr_write_data   = 32'h0;

        // Reset state and release
        rst_v = 1'b0;
        rd(12'hB00, 32'h0, 1'b0, "reset_mcycle");
        rd(12'h800, 32'h0, 1'b0, "reset_approx");
        rst_v = 1'b1;
        rd(12'hB00, 32'h0, 1'b0, "release_no_edge");
        rd(12'hB00, 32'h1, 1'b0, "release_first_edge");

        // Write / set / clear on approximation CSR 0; same-cycle read sees old value
        slot(1'b1, 12'h800, 1'b1, 2'b00, 12'h800, 32'hF0, 1'b1, 32'h0, 1'b0, "approx_write_read_old");
        approx_exp[31:0] = 32'hF0;
        slot(1'b1, 12'h800, 1'b1, 2'b01, 12'h800, 32'h0F, 1'b1, 32'hF0, 1'b0, "approx_after_write");
        approx_exp[31:0] = 32'hFF;
        slot(1'b1, 12'h800, 1'b1, 2'b10, 12'h800, 32'h3C, 1'b1, 32'hFF, 1'b0, "approx_after_set");
        approx_exp[31:0] = 32'hC3;
        rd(12'h800, 32'hC3, 1'b0, "approx_after_clear");

        // Illegal accesses leave state untouched; data is 0 without read strobe
        rd(12'h7FF, 32'h0, 1'b1, "read_unimplemented");
        slot(1'b0, 12'h800, 1'b1, 2'b00, 12'hC00, 32'hFFFF, 1'b1, 32'h0, 1'b1, "write_shadow");
        slot(1'b0, 12'h800, 1'b1, 2'b11, 12'h800, 32'h1234, 1'b1, 32'h0, 1'b1, "write_op_reserved");
        rd(12'h800, 32'hC3, 1'b0, "approx_unchanged");
        rd(12'h801, 32'h0, 1'b0, "approx1_legal");

        // Mid-run reset with a pending write
        wr(12'hB00, 2'b00, 32'h1234);
        rst_v = 1'b0;
        approx_exp = '0;
        slot(1'b1, 12'hB00, 1'b1, 2'b00, 12'h800, 32'hAAAA, 1'b1, 32'h0, 1'b0, "reset_mid_mcycle");
        rd(12'h800, 32'h0, 1'b0, "reset_hold_approx");
        rst_v = 1'b1;
        rd(12'hB00, 32'h0, 1'b0, "reset_release");
        rd(12'hB00, 32'h1, 1'b0, "reset_count_one");
        rd(12'h800, 32'h0, 1'b0, "pending_write_dropped");

        // Carry from low to high half, and full 64-bit wrap
        wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b00, 32'h0);
        rd(12'hB80, 32'h0, 1'b0, "pre_carry_hi");
        rd(12'hB00, 32'h0, 1'b0, "carry_lo");
        rd(12'hB80, 32'h1, 1'b0, "carry_hi");
        wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, 1'b0, "all_ones_lo");
        rd(12'hB00, 32'h0, 1'b0, "wrap_lo");
        rd(12'hB80, 32'h0, 1'b0, "wrap_hi");

        // Write beats increment in the same edge
        wr(12'hB00, 2'b00, 32'h100);
        rd(12'hB00, 32'h100, 1'b0, "write_priority");
        rd(12'hB00, 32'h101, 1'b0, "increment_after_write");

        // mcountinhibit freezes both counters, takes effect one edge late
        wr(12'hB00, 2'b00, 32'h200);
        wr(12'hB02, 2'b00, 32'h50);
        pulse_v = 1'b1;
        wr(12'h320, 2'b00, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) rd(12'hB00, 32'h202, 1'b0, "inhibit_mcycle_frozen");
            else            rd(12'hB02, 32'h51, 1'b0, "inhibit_minstret_frozen");
        end
        rd(12'h320, 32'h5, 1'b0, "inhibit_mask");
        slot(1'b1, 12'hB02, 1'b1, 2'b00, 12'h320, 32'h0, 1'b1, 32'h51, 1'b0, "inhibit_clear_edge");
        rd(12'hB00, 32'h202, 1'b0, "resume_old_inhibit_edge");
        pulse_v = 1'b0;
        rd(12'hB02, 32'h52, 1'b0, "resume_minstret");
        rd(12'hB00, 32'h204, 1'b0, "resume_mcycle");

        // User shadow counter
        wr(12'hB00, 2'b00, 32'h300);
`ifdef USER_COUNTER_SHADOW_EN
        rd(12'hC00, 32'h300, 1'b0, "shadow_cycle");
`else
        rd(12'hC00, 32'h0, 1'b1, "shadow_absent");
`endif

        slot(1'b0, 12'h000, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, "");
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
